unary_digit_collect: RTL and testbench
======================================

Name: unary_digit_collect

Overview:
- Downstream stage of the unary mod-13 adder. Consumes the adder's registered dout pulse train and carry C.
- Converts one unary digit back to binary and presents it with the captured carry on a valid/ready handshake.
- Feeds the binary digit assembler, which chains digits into multi-digit words.

Parameters:
MOD, 13, digit modulus; legal digit values are 0..MOD-1
CW, 4, width of the digit output, ceil(log2(MOD))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  stage enable, same net as the adder's en
read_or_write  input  1  phase select, same net as the adder's: 0 = read/accumulate phase, 1 = write/emit phase
din  input  1  adder dout (unary pulse stream)
cin  input  1  adder C (carry)
digit  output  CW  collected binary digit
carry  output  1  carry captured during the digit's read phase
ovf  output  1  more than MOD-1 pulses were seen; digit saturated
valid  output  1  digit/carry/ovf valid
ready  input  1  consumer accepts when valid && ready
overrun  output  1  sticky: a new read phase began while valid was unaccepted

Behaviour:
- Reset (rst=1, async): state=IDLE; digit=0; carry=0; ovf=0; valid=0; overrun=0; internal counter and carry_acc = 0.
- All state updates occur only when en=1, except the handshake: acceptance (valid && ready) is honoured regardless of en.
- IDLE:
  - While read_or_write=0: carry_acc <= carry_acc | cin.
  - On read_or_write=1: go to ARM and clear the counter.
- ARM: exists because the adder's dout and C are registered.
  - Exactly one cycle; din is ignored.
  - cin is still ORed into carry_acc, because the last read cycle's C appears here.
  - Next state is COUNT.
  - If read_or_write drops to 0 in ARM, return to IDLE: digit aborted, carry_acc kept.
- COUNT, per cycle with read_or_write=1:
  - din=1: counter increments. At MOD-1 the counter holds and ovf_int is set.
  - din=0: digit complete. Load digit=counter, carry=carry_acc, ovf=ovf_int; valid <= 1; go to VALID.
  - A zero digit completes on the first COUNT cycle.
  - If read_or_write drops to 0 in COUNT, treat it as completion with the current counter (same load as din=0).
- VALID:
  - Outputs are held stable until accepted.
  - Remaining write-phase cycles and din are ignored.
  - On acceptance: valid <= 0, carry_acc cleared, ovf_int cleared. Go to IDLE (whether read_or_write is 0 or 1).
  - If read_or_write returns to 0 while valid is still unaccepted:
    - overrun <= 1 (sticky until rst).
    - The pending result is held.
    - cin is not accumulated until acceptance, so that digit's carry is lost.
- Acceptance in the same cycle as completion is not possible. valid is registered; minimum latency is 1 cycle from the din=0 cycle to valid=1.
- Throughput is one digit per read/write phase pair. A consumer with ready tied high never causes overrun.
- Simultaneous events:
  - en=0 freezes the FSM and counter; acceptance is still processed.
  - rst overrides everything mid-operation, including a held valid.

Test Plan:
- Single digit 5, no carry: adder pulses 5 on din after ARM, ready=1 -> valid rises 1 cycle after the first din=0; digit=5, carry=0, ovf=0; one valid cycle.
- 12+1 wrap: cin=1 in the ARM cycle, din shows 0 pulses -> digit=0, carry=1.
- Back-pressure: digit 7 completes with ready=0 for 4 cycles, then ready=1 -> digit=7 held stable throughout; valid drops the cycle after acceptance; overrun=0.
- Overrun: ready=0, read_or_write returns to 0 with valid pending -> overrun=1 and stays; after acceptance the next digit 3 collects correctly.
- Saturation: 15 consecutive din=1 pulses -> digit=12, ovf=1.
- Async rst asserted mid-COUNT after 4 pulses -> all outputs 0 immediately. After release, a new phase with 2 pulses yields digit=2, carry=0.

Source files
------------

// File: rtl/unary_digit_collect_if.sv
// rtl/unary_digit_collect_if.sv - collected digit handshake bundle
// Master drives the digit result; slave returns ready.
interface unary_digit_collect_if #(
  parameter int CW = 4
);
  logic [CW-1:0] digit;
  logic          carry;
  logic          ovf;
  logic          valid;
  logic          ready;

  modport master (output digit, output carry, output ovf, output valid, input ready);
  modport slave  (input digit, input carry, input ovf, input valid, output ready);
endinterface

// File: rtl/unary_digit_collect.sv
// rtl/unary_digit_collect.sv - unary mod-MOD pulse train to binary digit collector
// Counts adder dout pulses in the write phase and emits digit + carry on valid/ready.
module unary_digit_collect #(
  parameter int MOD = 13,
  parameter int CW  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    read_or_write,
  input  logic                    din,
  input  logic                    cin,
  output logic                    overrun,
  unary_digit_collect_if.master   dig_if
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, VALID} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            ovf_int;
  logic            carry_acc;
  logic [CW-1:0]   digit_q;
  logic            carry_q;
  logic            ovf_q;
  logic            valid_q;

  logic            accept;
  logic            acc_or;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            load;
  logic            set_ovr;

  assign accept = valid_q && dig_if.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Acceptance wins over en so a stalled stage can still drain its result.
  always_comb begin
    state_nxt = state;
    acc_or    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    load      = 1'b0;
    set_ovr   = 1'b0;
    if (accept) begin
      state_nxt = IDLE;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (!read_or_write) begin
            acc_or = 1'b1;
          end else begin
            cnt_clr   = 1'b1;
            state_nxt = ARM;
          end
        end
        ARM: begin
          // Registered adder C lags by one cycle, so its last read value lands here.
          acc_or    = 1'b1;
          state_nxt = read_or_write ? COUNT : IDLE;
        end
        COUNT: begin
          if (read_or_write && din) begin
            cnt_inc = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = VALID;
          end
        end
        VALID: begin
          if (!read_or_write) set_ovr = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      ovf_int   <= 1'b0;
      carry_acc <= 1'b0;
      digit_q   <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        valid_q   <= 1'b0;
        carry_acc <= 1'b0;
        ovf_int   <= 1'b0;
      end
      if (acc_or)  carry_acc <= carry_acc | cin;
      if (cnt_clr) cnt <= '0;
      if (cnt_inc) begin
        if (cnt == CW'(MOD - 1)) ovf_int <= 1'b1;
        else                     cnt     <= cnt + 1'b1;
      end
      if (load) begin
        digit_q <= cnt;
        carry_q <= carry_acc;
        ovf_q   <= ovf_int;
        valid_q <= 1'b1;
      end
      if (set_ovr) overrun <= 1'b1;
    end
  end

  assign dig_if.digit = digit_q;
  assign dig_if.carry = carry_q;
  assign dig_if.ovf   = ovf_q;
  assign dig_if.valid = valid_q;

endmodule

// File: tb/tb_unary_digit_collect.sv
// tb/tb_unary_digit_collect.sv - randomized self-checking bench for unary_digit_collect
// Expected digits come from pulse counts and carry ORs of the driven stimulus.
module tb_unary_digit_collect;

  localparam int MOD = 13;
  localparam int CW  = 4;

  logic clk;
  logic rst;
  logic en;
  logic read_or_write;
  logic din;
  logic cin;
  logic overrun;

  int total;
  int bad;

  unary_digit_collect_if #(.CW(CW)) dig_if ();

  unary_digit_collect #(.MOD(MOD), .CW(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .read_or_write (read_or_write),
    .din           (din),
    .cin           (cin),
    .overrun       (overrun),
    .dig_if        (dig_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_digit(input int pulses);
    return (pulses > MOD - 1) ? MOD - 1 : pulses;
  endfunction

  // Drives one read phase plus write phase up to the completing din=0 cycle.
  task automatic drive_digit(input int pulses, input int read_len, input logic [7:0] read_cin,
                             input logic arm_cin, input bit gaps,
                             output int e_digit, output logic e_carry, output logic e_ovf);
    logic c;
    c = 1'b0;
    read_or_write = 1'b0;
    din = 1'b0;
    for (int i = 0; i < read_len; i++) begin
      cin = read_cin[i];
      c = c | read_cin[i];
      tick();
    end
    read_or_write = 1'b1;
    cin = 1'($urandom);
    din = 1'($urandom);
    tick();
    cin = arm_cin;
    c = c | arm_cin;
    din = 1'($urandom);
    tick();
    for (int k = 0; k < pulses; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        en = 1'b0;
        din = 1'($urandom);
        cin = 1'($urandom);
        tick();
        en = 1'b1;
      end
      din = 1'b1;
      cin = 1'($urandom);
      tick();
    end
    din = 1'b0;
    cin = 1'b0;
    tick();
    e_digit = model_digit(pulses);
    e_carry = c;
    e_ovf   = (pulses > MOD - 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    read_or_write = 1'b0;
    din = 1'b0;
    cin = 1'b0;
    dig_if.ready = 1'b0;
    tick();
    tick();
    total++;
    if ({dig_if.valid, dig_if.digit, dig_if.carry, dig_if.ovf, overrun} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got valid=%b digit=%0d carry=%b ovf=%b overrun=%b want all 0",
               dig_if.valid, dig_if.digit, dig_if.carry, dig_if.ovf, overrun);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int ed; logic ec, eo;
    dig_if.ready = 1'b1;
    drive_digit(5, 3, 8'h00, 1'b0, 1'b0, ed, ec, eo);
    total++;
    if (dig_if.valid !== 1'b1 || dig_if.digit !== CW'(ed) || dig_if.carry !== ec || dig_if.ovf !== eo) begin
      bad++;
      $display("FAIL single digit: got v=%b d=%0d c=%b o=%b want v=1 d=%0d c=%b o=%b",
               dig_if.valid, dig_if.digit, dig_if.carry, dig_if.ovf, ed, ec, eo);
    end
    read_or_write = 1'b0;
    tick();
    total++;
    if (dig_if.valid !== 1'b0) begin
      bad++;
      $display("FAIL single one-cycle valid: got %b want 0", dig_if.valid);
    end
  endtask

  task automatic test_wrap();
    int ed; logic ec, eo;
    dig_if.ready = 1'b1;
    drive_digit(0, 2, 8'h00, 1'b1, 1'b0, ed, ec, eo);
    total++;
    if (dig_if.valid !== 1'b1 || dig_if.digit !== 4'd0 || dig_if.carry !== 1'b1 || dig_if.ovf !== 1'b0) begin
      bad++;
      $display("FAIL wrap 12+1: got v=%b d=%0d c=%b o=%b want v=1 d=0 c=1 o=0",
               dig_if.valid, dig_if.digit, dig_if.carry, dig_if.ovf);
    end
    read_or_write = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    int ed; logic ec, eo;
    dig_if.ready = 1'b0;
    drive_digit(7, 2, 8'h00, 1'b0, 1'b0, ed, ec, eo);
    for (int i = 0; i < 4; i++) begin
      din = 1'($urandom);
      tick();
      total++;
      if (dig_if.valid !== 1'b1 || dig_if.digit !== 4'd7) begin
        bad++;
        $display("FAIL back-pressure hold %0d: got v=%b d=%0d want v=1 d=7", i, dig_if.valid, dig_if.digit);
      end
    end
    dig_if.ready = 1'b1;
    tick();
    read_or_write = 1'b0;
    total++;
    if (dig_if.valid !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL back-pressure release: got v=%b overrun=%b want v=0 overrun=0", dig_if.valid, overrun);
    end
    tick();
  endtask

  task automatic test_saturation();
    int ed; logic ec, eo;
    dig_if.ready = 1'b1;
    drive_digit(15, 1, 8'h00, 1'b0, 1'b0, ed, ec, eo);
    total++;
    if (dig_if.valid !== 1'b1 || dig_if.digit !== 4'd12 || dig_if.ovf !== 1'b1) begin
      bad++;
      $display("FAIL saturation: got v=%b d=%0d o=%b want v=1 d=12 o=1", dig_if.valid, dig_if.digit, dig_if.ovf);
    end
    read_or_write = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int ed, p, rl; logic ec, eo; logic [7:0] rc; logic ac;
    dig_if.ready = 1'b1;
    for (int it = 0; it < 24; it++) begin
      p  = (it == 0) ? 12 : (it == 1) ? 13 : int'($urandom_range(0, 15));
      rl = $urandom_range(1, 6);
      rc = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ac = ($urandom_range(0, 3) == 0);
      drive_digit(p, rl, rc, ac, 1'b1, ed, ec, eo);
      total++;
      if (dig_if.valid !== 1'b1 || dig_if.digit !== CW'(ed) || dig_if.carry !== ec || dig_if.ovf !== eo) begin
        bad++;
        $display("FAIL random %0d (pulses=%0d): got v=%b d=%0d c=%b o=%b want v=1 d=%0d c=%b o=%b",
                 it, p, dig_if.valid, dig_if.digit, dig_if.carry, dig_if.ovf, ed, ec, eo);
      end
      read_or_write = 1'b0;
      tick();
      total++;
      if (dig_if.valid !== 1'b0 || overrun !== 1'b0) begin
        bad++;
        $display("FAIL random %0d accept: got v=%b overrun=%b want 0 0", it, dig_if.valid, overrun);
      end
    end
  endtask

  task automatic test_overrun();
    int ed; logic ec, eo;
    dig_if.ready = 1'b0;
    drive_digit(4, 2, 8'h00, 1'b0, 1'b0, ed, ec, eo);
    read_or_write = 1'b0;
    cin = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (overrun !== 1'b1 || dig_if.valid !== 1'b1 || dig_if.digit !== 4'd4) begin
      bad++;
      $display("FAIL overrun set: got overrun=%b v=%b d=%0d want 1 1 4", overrun, dig_if.valid, dig_if.digit);
    end
    cin = 1'b0;
    dig_if.ready = 1'b1;
    tick();
    drive_digit(3, 2, 8'h00, 1'b0, 1'b0, ed, ec, eo);
    total++;
    if (dig_if.valid !== 1'b1 || dig_if.digit !== 4'd3 || dig_if.carry !== 1'b0 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun recovery: got v=%b d=%0d c=%b overrun=%b want 1 3 0 1",
               dig_if.valid, dig_if.digit, dig_if.carry, overrun);
    end
    read_or_write = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int ed; logic ec, eo;
    dig_if.ready = 1'b1;
    read_or_write = 1'b0;
    cin = 1'b1;
    tick();
    read_or_write = 1'b1;
    cin = 1'b0;
    tick();
    tick();
    din = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({dig_if.valid, dig_if.digit, dig_if.carry, dig_if.ovf, overrun} !== '0) begin
      bad++;
      $display("FAIL async reset: got v=%b d=%0d c=%b o=%b overrun=%b want all 0",
               dig_if.valid, dig_if.digit, dig_if.carry, dig_if.ovf, overrun);
    end
    read_or_write = 1'b0;
    din = 1'b0;
    tick();
    rst = 1'b0;
    drive_digit(2, 2, 8'h00, 1'b0, 1'b0, ed, ec, eo);
    total++;
    if (dig_if.valid !== 1'b1 || dig_if.digit !== 4'd2 || dig_if.carry !== 1'b0 || dig_if.ovf !== 1'b0) begin
      bad++;
      $display("FAIL post-reset digit: got v=%b d=%0d c=%b o=%b want 1 2 0 0",
               dig_if.valid, dig_if.digit, dig_if.carry, dig_if.ovf);
    end
    read_or_write = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_wrap();
    test_back_pressure();
    test_saturation();
    test_random();
    test_overrun();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
